// File: rtl/audio_block_accumulator.sv
// Block sum of BLOCK_LEN codec samples with a level "block_ready" flag for a NIOS PIO.
// Latency: final sample at edge t -> acc_sum/block_ready valid at t+1; all outputs registered.
// No backpressure: one sample per clock; an unacknowledged result drops later blocks and sets overrun.
// Build option: define ACCUM_ABS_EN to accumulate |sample| (unsigned level meter) instead of the signed sum.
module audio_block_accumulator #(
  parameter int SAMPLE_W  = 16,
  parameter int BLOCK_LEN = 256,
  parameter int ACC_W     = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                ack,
  output logic [ACC_W-1:0]    acc_sum,
  output logic                block_ready,
  output logic                overrun,
  output logic [15:0]         sample_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               rdy_q, rdy_d;
  logic               ovr_q, ovr_d;
  logic               pend_q, pend_d;

  logic [ACC_W-1:0]   sample_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               block_done;

`ifdef ACCUM_ABS_EN
  logic [SAMPLE_W:0]  sample_sx;
  logic [SAMPLE_W:0]  sample_mag;

  // Magnitude in SAMPLE_W+1 bits so the full-scale negative sample maps to +2^(SAMPLE_W-1).
  always_comb begin
    sample_sx  = {sample_data[SAMPLE_W-1], sample_data};
    sample_mag = sample_sx[SAMPLE_W] ? -sample_sx : sample_sx;
    sample_ext = {{(ACC_W-SAMPLE_W-1){1'b0}}, sample_mag};
  end
`else
  // Plain sign extension of the incoming sample to accumulator width.
  always_comb begin
    sample_ext = {{(ACC_W-SAMPLE_W){sample_data[SAMPLE_W-1]}}, sample_data};
  end
`endif

  // Next-state logic: accumulation FSM plus result/ready/overrun handoff to software.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    rdy_d      = rdy_q;
    ovr_d      = ovr_q;
    pend_d     = 1'b0;
    block_done = 1'b0;
    add_sum    = acc_q + sample_ext;

    // A result held back for one cycle re-raises the flag so the PIO sees a new edge.
    if (pend_q) begin
      rdy_d = 1'b1;
    end

    if (ack && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (sample_valid) begin
          if (cnt_q == 16'(BLOCK_LEN - 1)) begin
            block_done = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
          end else begin
            acc_d = add_sum;
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (block_done) begin
      if (!rdy_q && !pend_q) begin
        sum_d = add_sum;
        rdy_d = 1'b1;
      end else if (rdy_q && ack) begin
        // Drop the flag for exactly one cycle, then re-assert via pend_q.
        sum_d  = add_sum;
        rdy_d  = 1'b0;
        pend_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
    end
  end

  assign acc_sum      = sum_q;
  assign block_ready  = rdy_q;
  assign overrun      = ovr_q;
  assign sample_count = cnt_q;

endmodule

// File: doc/audio_block_accumulator.md
# audio_block_accumulator

Collects a fixed-length block of audio samples from the codec sample stream and sums them. When the block is complete, it latches the sum and raises a level flag, `block_ready`. `block_ready` drives the single-bit "Accumulate" PIO input, where the PIO's rising-edge capture interrupts the NIOS II. Software reads `acc_sum` through a separate PIO, then pulses `ack` to release the flag.

## Interface
Parameters:
- SAMPLE_W, 16, sample width; samples are two's-complement signed.
- BLOCK_LEN, 256, samples per block; legal range 2..65535.
- ACC_W, 24, accumulator width; must be ≥ SAMPLE_W + ceil(log2(BLOCK_LEN)).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  run control; low returns the block to IDLE.
- sample_valid  in  1  one-cycle strobe, one per audio sample.
- sample_data  in  SAMPLE_W  sample, valid when sample_valid=1.
- ack  in  1  one-cycle strobe from software: result consumed.
- acc_sum  out  ACC_W  latched block sum (signed; unsigned with ACCUM_ABS_EN).
- block_ready  out  1  level; high while an unacknowledged result is held.
- overrun  out  1  sticky; a completed block was dropped.
- sample_count  out  16  samples taken in the current block.

## Operation
- Reset (reset_n=0 at a clk edge) clears all of the following to 0 on that edge:
  - outputs: acc_sum, block_ready, overrun, sample_count;
  - internal: running accumulator, pending flag;
  - state returns to IDLE.
- State machine:
  - IDLE: accumulator and count held at 0; sample_valid ignored; enable=1 moves to ACCUM.
  - ACCUM: each sample_valid adds the sample, sign-extended to ACC_W, and increments sample_count.
  - The sample that makes the count equal BLOCK_LEN completes the block:
    - the running sum including that sample is the block result;
    - the running accumulator and count reset to 0 on the same edge;
    - accumulation continues with no lost sample.
  - ACCUM with enable=0 goes to IDLE and discards the partial block. acc_sum, block_ready and overrun are held.
- Result handling at block completion:
  - block_ready=0 and no pending: acc_sum ← result; block_ready ← 1.
  - block_ready=1 and ack=0: result discarded; acc_sum unchanged; overrun ← 1.
  - block_ready=1 and ack=1 in the same cycle:
    - acc_sum ← result; block_ready ← 0 for exactly one cycle, then 1 again;
    - uses an internal pending flag;
    - guarantees the downstream edge detector sees a fresh rising edge;
    - no overrun.
- ack with block_ready=1 clears block_ready and overrun on the next edge.
- ack with block_ready=0 has no effect.
- Arithmetic:
  - modular ACC_W-bit addition; no saturation;
  - parameter constraint guarantees no overflow for the full-scale negative sample −2^(SAMPLE_W−1), the worst case.

## Timing
- sample_valid at edge t: sample_count and the accumulator update at t+1.
- Final sample of a block at t: acc_sum and block_ready valid at t+1.
- ack at t: block_ready=0 at t+1.
- Pending re-assert after a simultaneous ack and completion: block_ready=1 at t+2.
- All outputs are registered; there is no combinational input→output path.
- sample_valid may assert on consecutive cycles; throughput is one sample per clock.

## Configuration
- ACCUM_ABS_EN defined:
  - each sample is replaced by its absolute value before accumulation;
  - −2^(SAMPLE_W−1) maps to 2^(SAMPLE_W−1), representable in SAMPLE_W+1 bits;
  - acc_sum is unsigned and serves as a level/energy meter for the effects UI.
- ACCUM_ABS_EN not defined: plain signed sum, i.e. DC estimate; acc_sum is two's-complement.

## Test plan
1. Reset, then enable=1 with BLOCK_LEN=4, samples 1,2,3,4 on consecutive cycles:
   - acc_sum=10 and block_ready=1 one cycle after the 4th sample;
   - sample_count=0.
2. Samples −32768 ×4, BLOCK_LEN=4, ACC_W=24:
   - without ACCUM_ABS_EN: acc_sum=0xFE0000;
   - with ACCUM_ABS_EN: acc_sum=0x020000.
3. Two full blocks (sums 10 and 20) with no ack:
   - acc_sum stays 10; overrun=1;
   - ack then clears block_ready and overrun the next cycle.
4. ack in the same cycle as the 2nd block's final sample (block sum 20):
   - block_ready sequence 1,0,1 over three cycles;
   - acc_sum=20; overrun=0.
5. enable dropped after 2 of 4 samples, then raised; samples 5,5,5,5:
   - acc_sum=20, confirming the partial block was discarded.
6. reset_n low for one edge mid-block while block_ready=1:
   - on the next cycle all outputs read 0;
   - the next block's sum excludes pre-reset samples.
